// File: rtl/matrix_result_tx_pkg.sv
// Shared constants for the result-matrix byte transmitter: geometry, frame
// length, FSM encoding and the per-element byte slicer.
package matrix_result_tx_pkg;

    localparam int N_ELEM         = 9;
    localparam int ELEM_W         = 18;
    localparam int BYTES_PER_ELEM = 3;
    localparam int FRAME_BYTES    = N_ELEM * BYTES_PER_ELEM;
    localparam int FLAT_W         = N_ELEM * ELEM_W;
    localparam int PAD_W          = 8 * BYTES_PER_ELEM;

    localparam int ELEM_IDX_W     = 4;
    localparam int BYTE_IDX_W     = 2;

    localparam logic [ELEM_IDX_W-1:0] LAST_ELEM = ELEM_IDX_W'(N_ELEM - 1);
    localparam logic [BYTE_IDX_W-1:0] LAST_BYTE = BYTE_IDX_W'(BYTES_PER_ELEM - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

    // Little-endian slice of one entry; the top byte is zero-extended.
    function automatic logic [7:0] elem_byte(input logic [ELEM_W-1:0] e,
                                             input logic [BYTE_IDX_W-1:0] b);
        logic [PAD_W-1:0] padded;
        logic [7:0]       r;
        padded = {{(PAD_W - ELEM_W){1'b0}}, e};
        case (b)
            2'd0:    r = padded[7:0];
            2'd1:    r = padded[15:8];
            default: r = padded[23:16];
        endcase
        return r;
    endfunction

endpackage

// File: rtl/matrix_result_tx.sv
// Byte-serial valid/ready transmitter for the 3x3 result matrix: snapshots C
// on start, streams 27 little-endian bytes, then pulses done for one cycle.
module matrix_result_tx
    import matrix_result_tx_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [FLAT_W-1:0] c_flat,
    input  logic              out_ready,
    output logic [7:0]        out_data,
    output logic              out_valid,
    output logic              busy,
    output logic              done
);

    logic [1:0]                       state;
    logic [N_ELEM-1:0][ELEM_W-1:0]    snap;
    logic [ELEM_IDX_W-1:0]            elem_idx;
    logic [BYTE_IDX_W-1:0]            byte_idx;

    logic                             xfer;
    logic                             last_xfer;
    logic [ELEM_IDX_W-1:0]            nxt_elem;
    logic [BYTE_IDX_W-1:0]            nxt_byte;
    logic [7:0]                       nxt_data;

    assign xfer      = out_valid && out_ready;
    assign last_xfer = xfer && (elem_idx == LAST_ELEM) && (byte_idx == LAST_BYTE);

    // Index of the byte that follows the one currently on the wire.
    always_comb begin
        nxt_elem = elem_idx;
        nxt_byte = byte_idx + 1'b1;
        if (byte_idx == LAST_BYTE) begin
            nxt_byte = '0;
            nxt_elem = elem_idx + 1'b1;
        end
    end

    // nxt_elem only reaches past the last entry on the final transfer, where
    // nxt_data is not used.
    always_comb begin
        nxt_data = 8'h00;
        if (nxt_elem <= LAST_ELEM)
            nxt_data = elem_byte(snap[nxt_elem], nxt_byte);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            snap      <= '0;
            elem_idx  <= '0;
            byte_idx  <= '0;
            out_data  <= 8'h00;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        snap      <= c_flat;
                        elem_idx  <= '0;
                        byte_idx  <= '0;
                        out_data  <= elem_byte(c_flat[ELEM_W-1:0], '0);
                        out_valid <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    // Without a transfer everything holds, so the byte is
                    // stable under backpressure.
                    if (last_xfer) begin
                        elem_idx  <= '0;
                        byte_idx  <= '0;
                        out_data  <= 8'h00;
                        out_valid <= 1'b0;
                        done      <= 1'b1;
                        state     <= ST_FIN;
                    end else if (xfer) begin
                        elem_idx <= nxt_elem;
                        byte_idx <= nxt_byte;
                        out_data <= nxt_data;
                    end
                end
                ST_FIN: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    out_data  <= 8'h00;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_result_tx.sv
// Scoreboard bench: stimulus pushes the expected byte stream for each frame,
// a negedge monitor pops and compares on every valid/ready handshake.
module tb_matrix_result_tx;
    import matrix_result_tx_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [FLAT_W-1:0] c_flat = '0;
    logic              out_ready = 1'b0;
    logic [7:0]        out_data;
    logic              out_valid;
    logic              busy;
    logic              done;

    matrix_result_tx dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .c_flat    (c_flat),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0]        exp_q[$];
    int                done_q[$];
    int                first_q[$];
    int                nbytes = 0;
    bit                pend_done = 1'b0;
    bit                prev_valid = 1'b0;
    bit                prev_ready = 1'b0;
    logic [7:0]        prev_data = 8'h00;
    int                rmode = 0;
    logic [ELEM_W-1:0] cm [N_ELEM];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: each entry as three little-endian bytes, entries ascending.
    task automatic push_frame();
        for (int k = 0; k < N_ELEM; k++)
            for (int b = 0; b < BYTES_PER_ELEM; b++)
                exp_q.push_back(8'((int'(cm[k]) >> (8 * b)) & 255));
    endtask

    task automatic apply_c();
        for (int k = 0; k < N_ELEM; k++)
            c_flat[k*ELEM_W +: ELEM_W] = cm[k];
    endtask

    task automatic rand_c();
        for (int k = 0; k < N_ELEM; k++)
            cm[k] = ELEM_W'($urandom);
        apply_c();
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("done_timing", int'(done), int'(pend_done));
            pend_done = 1'b0;
            if (done) done_q.push_back(cyc);
            chk("busy", int'(busy), int'(out_valid || done));
            if (!out_valid) chk("idle_data", int'(out_data), 0);
            if (prev_valid && !prev_ready) begin
                chk("hold_valid", int'(out_valid), 1);
                chk("hold_data", int'(out_data), int'(prev_data));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_byte: got %0h, expected none", out_data);
                end else begin
                    chk("byte", int'(out_data), int'(exp_q.pop_front()));
                end
                if (nbytes == 0) first_q.push_back(cyc);
                nbytes++;
                if (nbytes == FRAME_BYTES) begin
                    nbytes    = 0;
                    pend_done = 1'b1;
                end
            end
            prev_valid = out_valid;
            prev_ready = out_ready;
            prev_data  = out_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rmode == 1) out_ready = ($urandom_range(0, 9) < 7);
    endtask

    task automatic pulse_start(output int e);
        start = 1'b1;
        tick();
        start = 1'b0;
        e = cyc;
    endtask

    task automatic wait_idle(input string name, input int maxc);
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < maxc) begin
            tick();
            n++;
        end
        if (n >= maxc) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_timeout: got busy after %0d cycles, expected idle", name, n);
        end
        tick();
        tick();
    endtask

    task automatic wait_bytes(input string name, input int target);
        int n = 0;
        while (!(nbytes == target && out_valid) && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_timeout: got %0d bytes, expected %0d", name, nbytes, target);
        end
    endtask

    initial begin
        int e;
        int e2;
        int ok;

        // reset state
        repeat (3) tick();
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_data", int'(out_data), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        rst_n = 1'b1;
        tick();

        // T1: C[k]=k+1, ready high, latency
        rmode = 0;
        out_ready = 1'b1;
        for (int k = 0; k < N_ELEM; k++) cm[k] = ELEM_W'(k + 1);
        apply_c();
        first_q.delete();
        done_q.delete();
        push_frame();
        pulse_start(e);
        wait_idle("t1", 100);
        chk("t1_frames", first_q.size(), 1);
        chk("t1_dones", done_q.size(), 1);
        if (first_q.size() == 1) chk("t1_first_cycle", first_q[0] - e + 1, 1);
        if (done_q.size() == 1) chk("t1_done_cycle", done_q[0] - e + 1, 28);

        // T2: boundary values
        for (int k = 0; k < N_ELEM; k++) cm[k] = '0;
        cm[0] = 18'h3FFFF;
        cm[4] = 18'h12345;
        apply_c();
        push_frame();
        pulse_start(e);
        wait_idle("t2", 100);

        // T3: 5 cycles of backpressure on byte index 4
        rand_c();
        push_frame();
        pulse_start(e);
        wait_bytes("t3", 4);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("t3_stall_byte", int'(out_data), (int'(cm[1]) >> 8) & 255);
            tick();
        end
        out_ready = 1'b1;
        chk("t3_after_stall", int'(out_data), (int'(cm[1]) >> 8) & 255);
        wait_idle("t3", 100);

        // T4: c_flat changes after capture, start re-pulsed mid-frame
        rand_c();
        done_q.delete();
        push_frame();
        pulse_start(e);
        tick();
        c_flat = '1;
        wait_bytes("t4", 10);
        pulse_start(e2);
        wait_idle("t4", 100);
        chk("t4_dones", done_q.size(), 1);

        // T5: reset while byte 10 is presented
        rand_c();
        push_frame();
        pulse_start(e);
        wait_bytes("t5", 10);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", int'(out_valid), 0);
        chk("t5_rst_data", int'(out_data), 0);
        chk("t5_rst_busy", int'(busy), 0);
        chk("t5_rst_done", int'(done), 0);
        exp_q.delete();
        nbytes     = 0;
        pend_done  = 1'b0;
        prev_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        rand_c();
        push_frame();
        pulse_start(e);
        wait_idle("t5", 100);

        // T6: start held high across two frames
        rand_c();
        done_q.delete();
        first_q.delete();
        push_frame();
        push_frame();
        start = 1'b1;
        ok = 0;
        while (done_q.size() == 0 && ok < 100) begin
            tick();
            ok++;
        end
        repeat (3) tick();
        start = 1'b0;
        wait_idle("t6", 100);
        chk("t6_dones", done_q.size(), 2);
        if (done_q.size() == 2) chk("t6_done_spacing", done_q[1] - done_q[0], 29);
        if (first_q.size() == 2) chk("t6_frame_spacing", first_q[1] - first_q[0], 29);

        // T7: randomized frames with random ready and stray start pulses
        rmode = 1;
        for (int f = 0; f < 6; f++) begin
            rand_c();
            push_frame();
            pulse_start(e);
            for (int i = 0; i < 15; i++) begin
                start = ($urandom_range(0, 7) == 0) && busy;
                tick();
            end
            start = 1'b0;
            wait_idle("t7", 400);
        end
        rmode = 0;
        out_ready = 1'b1;
        repeat (3) tick();
        chk("end_queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
